// File: rtl/vga_timing_pkg.sv
// Shared raster-timing types, default 640x480@60 timing and total-length helper.
package vga_timing_pkg;

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FRONT  = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BACK   = 2'd3
   } phase_e;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;
   localparam int unsigned DEF_CW       = 10;

   // Total period of one axis from its four interval lengths.
   function automatic int unsigned axis_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// wrap is combinational and flags the step that returns count to 0.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned FP     = DEF_H_FP,
   parameter int unsigned SYNC   = DEF_H_SYNC,
   parameter int unsigned BP     = DEF_H_BP,
   parameter int unsigned CW     = DEF_CW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          step,
   output logic [CW-1:0] count,
   output phase_e        phase,
   output logic          wrap
);

   localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

   localparam logic [CW-1:0] END_ACTIVE = CW'(ACTIVE - 1);
   localparam logic [CW-1:0] END_FRONT  = CW'(ACTIVE + FP - 1);
   localparam logic [CW-1:0] END_SYNC   = CW'(ACTIVE + FP + SYNC - 1);
   localparam logic [CW-1:0] END_TOTAL  = CW'(TOTAL - 1);

   // Reject empty intervals and counters too narrow for the period.
   if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_bad_length
      $fatal(1, "vga_axis_counter: interval lengths must be non-zero");
   end
   if (((TOTAL - 1) >> CW) != 0) begin : g_bad_width
      $fatal(1, "vga_axis_counter: CW too small for axis total");
   end

   phase_e        phase_nxt;
   logic [CW-1:0] count_nxt;
   logic          at_end;

   assign at_end = (count == END_TOTAL);
   assign wrap   = step && at_end;

   // Counter and phase register, advancing only on step.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         phase <= PH_ACTIVE;
      end else if (step) begin
         count <= count_nxt;
         phase <= phase_nxt;
      end
   end

   // Next position and phase at interval boundaries.
   always_comb begin
      phase_nxt = phase;
      count_nxt = at_end ? '0 : count + CW'(1);
      case (phase)
         PH_ACTIVE: if (count == END_ACTIVE) phase_nxt = PH_FRONT;
         PH_FRONT:  if (count == END_FRONT)  phase_nxt = PH_SYNC;
         PH_SYNC:   if (count == END_SYNC)   phase_nxt = PH_BACK;
         PH_BACK:   if (at_end)              phase_nxt = PH_ACTIVE;
         default:   phase_nxt = PH_ACTIVE;
      endcase
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: registered hs/vs/de, position and line/frame
// start pulses, one cycle behind the internal counters.
// Optional colour-bar test pattern: define VGA_SYNC_GEN_TEST_PATTERN_EN.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned CW       = DEF_CW
) (
   input  logic          clk_pix,
   input  logic          rst,
   input  logic          en,
   output logic          hs,
   output logic          vs,
   output logic          de,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          sol,
   output logic          sof,
   output logic          vga_r,
   output logic          vga_g,
   output logic          vga_b
);

   logic [CW-1:0] h_cnt;
   logic [CW-1:0] v_cnt;
   phase_e        h_ph;
   phase_e        v_ph;
   logic          h_wrap;
   logic          v_wrap_unused;
   logic          v_step;
   logic          de_c;

   assign v_step = en && h_wrap;
   assign de_c   = (h_ph == PH_ACTIVE) && (v_ph == PH_ACTIVE);

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .CW     (CW)
   ) u_h_axis (
      .clk   (clk_pix),
      .rst   (rst),
      .step  (en),
      .count (h_cnt),
      .phase (h_ph),
      .wrap  (h_wrap)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .CW     (CW)
   ) u_v_axis (
      .clk   (clk_pix),
      .rst   (rst),
      .step  (v_step),
      .count (v_cnt),
      .phase (v_ph),
      .wrap  (v_wrap_unused)
   );

   // Register timing outputs from the current counter state; hold when stalled.
   always_ff @(posedge clk_pix) begin
      if (rst) begin
         hs  <= ~HS_POL;
         vs  <= ~VS_POL;
         de  <= 1'b0;
         x   <= '0;
         y   <= '0;
         sol <= 1'b0;
         sof <= 1'b0;
      end else if (en) begin
         hs  <= (h_ph == PH_SYNC) ? HS_POL : ~HS_POL;
         vs  <= (v_ph == PH_SYNC) ? VS_POL : ~VS_POL;
         de  <= de_c;
         x   <= h_cnt;
         y   <= v_cnt;
         sol <= (h_cnt == '0);
         sof <= (h_cnt == '0) && (v_cnt == '0);
      end
   end

`ifdef VGA_SYNC_GEN_TEST_PATTERN_EN
   localparam int unsigned BAR_W = (H_ACTIVE / 8 == 0) ? 1 : H_ACTIVE / 8;

   logic [2:0] bar_c;
   logic [2:0] rgb_q;

   assign bar_c = 3'(h_cnt / CW'(BAR_W));

   // Eight vertical bars, white at the left edge down to black; blank outside de.
   always_ff @(posedge clk_pix) begin
      if (rst) begin
         rgb_q <= 3'b000;
      end else if (en) begin
         rgb_q <= de_c ? ~bar_c : 3'b000;
      end
   end

   assign {vga_r, vga_g, vga_b} = rgb_q;
`else
   assign vga_r = 1'b0;
   assign vga_g = 1'b0;
   assign vga_b = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen using a shrunken raster (24x10 total)
// and a position-based reference model. Honours VGA_SYNC_GEN_TEST_PATTERN_EN.
module tb_vga_sync_gen;

   localparam int unsigned HA  = 16;
   localparam int unsigned HFP = 2;
   localparam int unsigned HSY = 3;
   localparam int unsigned HBP = 3;
   localparam int unsigned VA  = 6;
   localparam int unsigned VFP = 1;
   localparam int unsigned VSY = 2;
   localparam int unsigned VBP = 1;
   localparam int unsigned CW  = 10;
   localparam int unsigned HT  = HA + HFP + HSY + HBP;
   localparam int unsigned VT  = VA + VFP + VSY + VBP;
   localparam bit          HPOL = 1'b0;
   localparam bit          VPOL = 1'b0;
   localparam int unsigned VW  = 8 + 2 * CW;
`ifdef VGA_SYNC_GEN_TEST_PATTERN_EN
   localparam bit TP = 1'b1;
`else
   localparam bit TP = 1'b0;
`endif

   logic          clk_pix = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          hs, vs, de, sol, sof, vga_r, vga_g, vga_b;
   logic [CW-1:0] x, y;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference model: raster position plus expected registered outputs.
   int            m_h = 0;
   int            m_v = 0;
   logic          e_hs, e_vs, e_de, e_sol, e_sof;
   logic [2:0]    e_rgb;
   logic [CW-1:0] e_x, e_y;

   vga_sync_gen #(
      .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
      .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
      .HS_POL   (HPOL), .VS_POL (VPOL), .CW (CW)
   ) dut (
      .clk_pix (clk_pix), .rst (rst), .en (en),
      .hs (hs), .vs (vs), .de (de), .x (x), .y (y),
      .sol (sol), .sof (sof),
      .vga_r (vga_r), .vga_g (vga_g), .vga_b (vga_b)
   );

   always #5 clk_pix = ~clk_pix;

   function automatic logic [VW-1:0] dut_vec();
      return {hs, vs, de, sol, sof, vga_r, vga_g, vga_b, x, y};
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      return {e_hs, e_vs, e_de, e_sol, e_sof, e_rgb, e_x, e_y};
   endfunction

   function automatic logic [VW-1:0] reset_vec();
      return {~HPOL, ~VPOL, 1'b0, 1'b0, 1'b0, 3'b000, CW'(0), CW'(0)};
   endfunction

   task automatic model_step(input bit r, input bit e);
      if (r) begin
         m_h = 0; m_v = 0;
         e_hs = ~HPOL; e_vs = ~VPOL; e_de = 1'b0; e_sol = 1'b0; e_sof = 1'b0;
         e_rgb = 3'b000; e_x = '0; e_y = '0;
      end else if (e) begin
         e_x   = CW'(m_h);
         e_y   = CW'(m_v);
         e_hs  = (m_h >= int'(HA + HFP) && m_h < int'(HA + HFP + HSY)) ? HPOL : ~HPOL;
         e_vs  = (m_v >= int'(VA + VFP) && m_v < int'(VA + VFP + VSY)) ? VPOL : ~VPOL;
         e_de  = (m_h < int'(HA)) && (m_v < int'(VA));
         e_sol = (m_h == 0);
         e_sof = (m_h == 0) && (m_v == 0);
         e_rgb = (TP && e_de) ? ~3'(m_h / int'(HA / 8)) : 3'b000;
         m_h = m_h + 1;
         if (m_h == int'(HT)) begin
            m_h = 0;
            m_v = (m_v + 1) % int'(VT);
         end
      end
   endtask

   task automatic tick(input bit r, input bit e);
      rst = r;
      en  = e;
      @(posedge clk_pix);
      #1;
      cyc++;
      model_step(r, e);
   endtask

   task automatic goto_pos(input int tx, input int ty);
      int n = 0;
      while (!(x == CW'(tx) && y == CW'(ty)) && n < int'(2 * HT * VT)) begin
         tick(1'b0, 1'b1);
         n++;
      end
      checks++;
      if (!(x == CW'(tx) && y == CW'(ty))) begin
         errors++;
         $display("FAIL goto_timeout: at (%0d,%0d) wanted (%0d,%0d)", x, y, tx, ty);
      end
   endtask

   task automatic test_reset();
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b0);
      checks++;
      if (dut_vec() !== reset_vec()) begin
         errors++;
         $display("FAIL reset_state: got %h want %h", dut_vec(), reset_vec());
      end
      tick(1'b0, 1'b1);
      checks++;
      if ({x, y, de, sol, sof} !== {CW'(0), CW'(0), 3'b111}) begin
         errors++;
         $display("FAIL first_cycle: x=%0d y=%0d de=%b sol=%b sof=%b want 0 0 1 1 1",
                  x, y, de, sol, sof);
      end
      goto_pos(HA - 1, 0);
      checks++;
      if (de !== 1'b1) begin
         errors++;
         $display("FAIL de_last_active: de=%b want 1", de);
      end
      tick(1'b0, 1'b1);
      checks++;
      if ({x, de} !== {CW'(HA), 1'b0}) begin
         errors++;
         $display("FAIL de_first_blank: x=%0d de=%b want %0d 0", x, de, HA);
      end
   endtask

   task automatic test_line_timing();
      int hs_cnt = 0;
      int hs_x = -1;
      int last_sol;
      goto_pos(0, 1);
      last_sol = cyc;
      for (int i = 0; i < int'(3 * HT); i++) begin
         tick(1'b0, 1'b1);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL line_model: got %h want %h", dut_vec(), exp_vec());
         end
         if (hs === HPOL) begin
            hs_cnt++;
            if (hs_x < 0) hs_x = int'(x);
         end
         if (sol === 1'b1) begin
            checks++;
            if (cyc - last_sol != int'(HT)) begin
               errors++;
               $display("FAIL sol_period: got %0d want %0d", cyc - last_sol, HT);
            end
            last_sol = cyc;
         end
      end
      checks++;
      if (hs_cnt != int'(3 * HSY)) begin
         errors++;
         $display("FAIL hs_width: got %0d want %0d", hs_cnt, 3 * HSY);
      end
      checks++;
      if (hs_x != int'(HA + HFP)) begin
         errors++;
         $display("FAIL hs_start: got x=%0d want %0d", hs_x, HA + HFP);
      end
   endtask

   task automatic test_frame_timing();
      int vs_cnt = 0;
      int de_cnt = 0;
      int vs_x = -1;
      int vs_y = -1;
      int last_sof;
      goto_pos(0, 0);
      last_sof = cyc;
      for (int i = 0; i < int'(2 * HT * VT); i++) begin
         tick(1'b0, 1'b1);
         if (vs === VPOL) begin
            vs_cnt++;
            if (vs_y < 0) begin vs_x = int'(x); vs_y = int'(y); end
         end
         if (de === 1'b1) de_cnt++;
         if (sof === 1'b1) begin
            checks++;
            if (cyc - last_sof != int'(HT * VT)) begin
               errors++;
               $display("FAIL sof_period: got %0d want %0d", cyc - last_sof, HT * VT);
            end
            last_sof = cyc;
         end
      end
      checks++;
      if (vs_cnt != int'(2 * VSY * HT)) begin
         errors++;
         $display("FAIL vs_width: got %0d want %0d", vs_cnt, 2 * VSY * HT);
      end
      checks++;
      if (vs_x != 0 || vs_y != int'(VA + VFP)) begin
         errors++;
         $display("FAIL vs_start: got (%0d,%0d) want (0,%0d)", vs_x, vs_y, VA + VFP);
      end
      checks++;
      if (de_cnt != int'(2 * HA * VA)) begin
         errors++;
         $display("FAIL de_count: got %0d want %0d", de_cnt, 2 * HA * VA);
      end
   endtask

   task automatic test_stall();
      logic [VW-1:0] held;
      goto_pos(10, 2);
      held = dut_vec();
      for (int i = 0; i < 2; i++) begin
         tick(1'b0, 1'b0);
         checks++;
         if (dut_vec() !== held || x !== CW'(10)) begin
            errors++;
            $display("FAIL stall_hold: got %h want %h", dut_vec(), held);
         end
      end
      tick(1'b0, 1'b1);
      checks++;
      if (x !== CW'(11)) begin
         errors++;
         $display("FAIL stall_resume: x=%0d want 11", x);
      end
      for (int i = 0; i < 600; i++) begin
         tick($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random_model: cyc=%0d got %h want %h", cyc, dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_mid_reset();
      goto_pos(HA + HFP + HSY, 5);
      tick(1'b1, 1'b1);
      checks++;
      if (dut_vec() !== reset_vec()) begin
         errors++;
         $display("FAIL mid_reset_state: got %h want %h", dut_vec(), reset_vec());
      end
      tick(1'b0, 1'b1);
      checks++;
      if ({x, y, sof, hs} !== {CW'(0), CW'(0), 1'b1, ~HPOL}) begin
         errors++;
         $display("FAIL mid_reset_restart: x=%0d y=%0d sof=%b hs=%b", x, y, sof, hs);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
         errors++;
         $display("FAIL mid_reset_model: got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_pattern();
      logic [2:0] want;
      logic [2:0] bar;
      goto_pos(0, 3);
      for (int xi = 0; xi <= int'(HA); xi++) begin
         bar  = 3'(xi / int'(HA / 8));
         want = (TP && xi < int'(HA)) ? ~bar : 3'b000;
         checks++;
         if ({vga_r, vga_g, vga_b} !== want || x !== CW'(xi)) begin
            errors++;
            $display("FAIL pattern_rgb: x=%0d got %b want %b", x, {vga_r, vga_g, vga_b}, want);
         end
         tick(1'b0, 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_line_timing();
      test_frame_timing();
      test_stall();
      test_mid_reset();
      test_pattern();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
